// File: rtl/ram_ctrl_if.sv
// ----------------------------------------------------------------------------
// ram_ctrl_if
//   Request/response bundle between the CPU load/store path and ram_ctrl.
//   master : CPU side (issues requests, consumes read responses)
//   slave  : ram_ctrl side
//   Signals
//     req_valid / req_ready   request handshake
//     req_we                  1 = store, 0 = load
//     req_addr / req_wdata    request address and store data
//     rsp_valid / rsp_ready   read-response handshake
//     rsp_data                captured read data
// ----------------------------------------------------------------------------
interface ram_ctrl_if #(
    parameter int ADDR_SIZE = 2,
    parameter int DATA_SIZE = 8
) ();
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [ADDR_SIZE-1:0] req_addr;
    logic [DATA_SIZE-1:0] req_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DATA_SIZE-1:0] rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/ram_ctrl.sv
// ----------------------------------------------------------------------------
// ram_ctrl
//   Clocked front-end for an asynchronous, level-sensitive ram. Converts
//   valid/ready load/store requests into ram pin sequences where WE (active
//   low write strobe) only falls while ADDRESS and ram_in are already stable.
//   After reset every ram word is cleared to INIT_VALUE (when INIT_EN=1).
//   Ports
//     CLK, RST      clock (rising edge), synchronous active-high reset
//     bus           ram_ctrl_if slave: request and read-response handshakes
//     init_done     clear finished, sticky until RST
//     mem_WE        ram WE (0 = write strobe), registered
//     mem_ADDRESS   ram ADDRESS, registered
//     mem_wdata     ram ram_in, registered
//     mem_rdata     ram ram_out
// ----------------------------------------------------------------------------
module ram_ctrl #(
    parameter int ADDR_SIZE  = 2,
    parameter int DATA_SIZE  = 8,
    parameter int RD_WAIT    = 1,
    parameter int INIT_EN    = 1,
    parameter int INIT_VALUE = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    ram_ctrl_if.slave            bus,
    output logic                 init_done,
    output logic                 mem_WE,
    output logic [ADDR_SIZE-1:0] mem_ADDRESS,
    output logic [DATA_SIZE-1:0] mem_wdata,
    input  logic [DATA_SIZE-1:0] mem_rdata
);
    localparam logic [2:0] S_INIT    = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_WSETUP  = 3'd2;
    localparam logic [2:0] S_WSTROBE = 3'd3;
    localparam logic [2:0] S_WHOLD   = 3'd4;
    localparam logic [2:0] S_RWAIT   = 3'd5;
    localparam logic [2:0] S_RESP    = 3'd6;

    localparam logic [DATA_SIZE-1:0] INIT_WORD = DATA_SIZE'(INIT_VALUE);
    localparam logic [ADDR_SIZE:0]   INIT_LAST = '1;
    localparam logic [3:0]           RD_LOAD   = 4'(RD_WAIT - 1);
    // ram_in already carries the clear word on the first clear cycle, so the
    // first strobe never coincides with a data change.
    localparam logic [DATA_SIZE-1:0] RST_WDATA = (INIT_EN != 0) ? INIT_WORD : '0;

    logic [2:0]           state;
    // Clear sequencer: upper bits are the word address, LSB selects the
    // setup (0) or strobe (1) half of each word's two-cycle slot.
    logic [ADDR_SIZE:0]   init_cnt;
    logic [ADDR_SIZE:0]   init_nxt;
    logic [3:0]           rd_cnt;

    assign init_nxt      = init_cnt + 1'b1;
    assign bus.req_ready = (state == S_IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= (INIT_EN != 0) ? S_INIT : S_IDLE;
            init_cnt      <= '0;
            rd_cnt        <= '0;
            init_done     <= (INIT_EN == 0);
            mem_WE        <= 1'b1;
            mem_ADDRESS   <= '0;
            mem_wdata     <= RST_WDATA;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    if (!init_cnt[0]) begin
                        mem_WE   <= 1'b0;
                        init_cnt <= init_nxt;
                    end else if (init_cnt == INIT_LAST) begin
                        mem_WE    <= 1'b1;
                        init_cnt  <= '0;
                        init_done <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        mem_WE      <= 1'b1;
                        mem_ADDRESS <= init_nxt[ADDR_SIZE:1];
                        init_cnt    <= init_nxt;
                    end
                end
                S_IDLE: begin
                    if (bus.req_valid) begin
                        mem_ADDRESS <= bus.req_addr;
                        if (bus.req_we) begin
                            mem_wdata <= bus.req_wdata;
                            state     <= S_WSETUP;
                        end else begin
                            rd_cnt <= RD_LOAD;
                            state  <= S_RWAIT;
                        end
                    end
                end
                S_WSETUP: begin
                    mem_WE <= 1'b0;
                    state  <= S_WSTROBE;
                end
                S_WSTROBE: begin
                    mem_WE <= 1'b1;
                    state  <= S_WHOLD;
                end
                S_WHOLD: begin
                    state <= S_IDLE;
                end
                S_RWAIT: begin
                    // ram_out has had RD_WAIT cycles to settle when the count expires
                    if (rd_cnt == 4'd0) begin
                        bus.rsp_data  <= mem_rdata;
                        bus.rsp_valid <= 1'b1;
                        state         <= S_RESP;
                    end else begin
                        rd_cnt <= rd_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    mem_WE <= 1'b1;
                    state  <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ram_ctrl
//   Bench for ram_ctrl. A behavioural ram array sits on the mem_* pins.
//   A timeline model (cycles since reset / since request acceptance) predicts
//   every output each cycle; directed sequences pin literal values, and a
//   second instance covers RD_WAIT=3 with the clear disabled.
// ----------------------------------------------------------------------------
module tb_ram_ctrl;
    localparam int AW = 2;
    localparam int DW = 8;
    localparam int DEPTH = 4;
    localparam int RDW = 1;
    localparam int IV = 0;
    localparam int INIT_CYC = 2 * DEPTH;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // ---------------- main instance (defaults) ----------------
    ram_ctrl_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();
    logic          init_done, mem_WE;
    logic [AW-1:0] mem_ADDRESS;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [DW-1:0] ram [DEPTH] = '{default: 8'hEE};

    ram_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .RD_WAIT(RDW), .INIT_EN(1), .INIT_VALUE(IV)) dut (
        .CLK(CLK), .RST(RST), .bus(bus.slave), .init_done(init_done), .mem_WE(mem_WE),
        .mem_ADDRESS(mem_ADDRESS), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

    assign mem_rdata = ram[mem_ADDRESS];
    always @(negedge CLK) if (mem_WE === 1'b0) ram[mem_ADDRESS] <= mem_wdata;

    // ---------------- second instance: RD_WAIT=3, no clear ----------------
    ram_ctrl_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus6 ();
    logic          init_done6, mem_WE6;
    logic [AW-1:0] mem_ADDRESS6;
    logic [DW-1:0] mem_wdata6, mem_rdata6;
    logic [DW-1:0] ram6 [DEPTH] = '{default: 8'hEE};

    ram_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .RD_WAIT(3), .INIT_EN(0), .INIT_VALUE(IV)) dut6 (
        .CLK(CLK), .RST(RST), .bus(bus6.slave), .init_done(init_done6), .mem_WE(mem_WE6),
        .mem_ADDRESS(mem_ADDRESS6), .mem_wdata(mem_wdata6), .mem_rdata(mem_rdata6));

    assign mem_rdata6 = ram6[mem_ADDRESS6];
    always @(negedge CLK) if (mem_WE6 === 1'b0) ram6[mem_ADDRESS6] <= mem_wdata6;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_init_n : cycles spent clearing since reset (clear done at INIT_CYC)
    // m_op     : 0 none, 1 write in flight, 2 read in flight
    // m_age    : edges since the accepting edge
    bit            m_live = 1'b0;
    int            m_init_n = 0;
    int            m_op = 0;
    int            m_age = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_pending = '0, m_last = '0;
    logic [DW-1:0] m_mem [DEPTH];
    logic          m_ini;
    assign m_ini = (m_init_n < INIT_CYC);

    always @(posedge CLK) begin
        if (RST) begin
            m_live   <= 1'b1;
            m_init_n <= 0;
            m_op     <= 0;
            m_age    <= 0;
            m_addr   <= '0;
            m_wdata  <= DW'(IV);
            m_last   <= '0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= DW'(IV);
        end else if (m_ini) begin
            m_addr   <= AW'(m_init_n / 2);
            m_init_n <= m_init_n + 1;
        end else if (m_op == 0) begin
            if (bus.req_valid) begin
                m_age  <= 0;
                m_addr <= bus.req_addr;
                if (bus.req_we) begin
                    m_op                <= 1;
                    m_wdata             <= bus.req_wdata;
                    m_mem[bus.req_addr] <= bus.req_wdata;
                end else begin
                    m_op      <= 2;
                    m_pending <= m_mem[bus.req_addr];
                end
            end
        end else if (m_op == 1) begin
            m_age <= m_age + 1;
            if (m_age == 2) m_op <= 0;
        end else begin
            if (m_age < RDW) m_age <= m_age + 1;
            else if (bus.rsp_ready) begin
                m_op   <= 0;
                m_last <= m_pending;
            end
        end
    end

    always @(negedge CLK) begin
        if (m_live) begin
            chk("cyc_req_ready", 32'(bus.req_ready), 32'(!m_ini && m_op == 0));
            chk("cyc_init_done", 32'(init_done), 32'(!m_ini));
            chk("cyc_mem_WE", 32'(mem_WE),
                m_ini ? 32'(m_init_n % 2 == 0) : 32'(!(m_op == 1 && m_age == 1)));
            chk("cyc_mem_ADDRESS", 32'(mem_ADDRESS), m_ini ? 32'(m_init_n / 2) : 32'(m_addr));
            chk("cyc_mem_wdata", 32'(mem_wdata), m_ini ? 32'(IV) : 32'(m_wdata));
            chk("cyc_rsp_valid", 32'(bus.rsp_valid), 32'(m_op == 2 && m_age >= RDW));
            chk("cyc_rsp_data", 32'(bus.rsp_data),
                (m_op == 2 && m_age >= RDW) ? 32'(m_pending) : 32'(m_last));
        end
    end

    // ---------------- directed helpers (all start/end on a negedge) ----------------
    logic [DW-1:0] sh [DEPTH] = '{default: 8'h00};

    task automatic wait_ready();
        int n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("ready_seen", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int lo = 0, nstb = 0;
        logic [AW-1:0] sa = '0;
        logic [DW-1:0] sd = '0;
        wait_ready();
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = a; bus.req_wdata = d;
        @(negedge CLK);
        bus.req_valid = 1'b0; bus.req_we = 1'($urandom); bus.req_wdata = DW'($urandom);
        while (!bus.req_ready && lo < 20) begin
            if (mem_WE === 1'b0) begin
                nstb++; sa = mem_ADDRESS; sd = mem_wdata;
            end
            lo++;
            @(negedge CLK);
        end
        chk("wr_busy_cycles", 32'(lo), 32'd3);
        chk("wr_strobes", 32'(nstb), 32'd1);
        chk("wr_strobe_addr", 32'(sa), 32'(a));
        chk("wr_strobe_data", 32'(sd), 32'(d));
        sh[a] = d;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] want, input int stall);
        int lat = 0;
        wait_ready();
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = a; bus.req_wdata = DW'($urandom);
        @(negedge CLK);
        bus.req_valid = 1'b0; bus.req_we = 1'($urandom); bus.rsp_ready = 1'($urandom);
        while (!bus.rsp_valid && lat < 50) begin
            @(negedge CLK);
            lat++;
        end
        bus.rsp_ready = 1'b0;
        chk("rd_rsp_seen", 32'(bus.rsp_valid), 32'd1);
        if (!bus.rsp_valid) return;
        chk("rd_latency", 32'(lat), 32'd1);
        chk("rd_data", 32'(bus.rsp_data), 32'(want));
        for (int s = 0; s < stall; s++) begin
            @(negedge CLK);
            chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall_data", 32'(bus.rsp_data), 32'(want));
            chk("stall_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge CLK);
        bus.rsp_ready = 1'b0;
        chk("hs_valid_drop", 32'(bus.rsp_valid), 32'd0);
        chk("hs_idle", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic wait_init();
        int n = 0;
        while (!init_done && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("init_done_seen", 32'(init_done), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int mask, nstb, lat;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus6.req_valid = 1'b0; bus6.req_we = 1'b0; bus6.req_addr = '0; bus6.req_wdata = '0;
        bus6.rsp_ready = 1'b0;
        RST = 1'b1;
        repeat (3) @(negedge CLK);

        // reset values
        chk("rst_mem_WE", 32'(mem_WE), 32'd1);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_addr", 32'(mem_ADDRESS), 32'd0);
        chk("t6_init_done", 32'(init_done6), 32'd1);
        chk("t6_ready", 32'(bus6.req_ready), 32'd1);

        // clear sequence: 8 edges, one strobe per address
        RST = 1'b0;
        mask = 0; nstb = 0;
        for (int e = 0; e <= INIT_CYC; e++) begin
            if (e > 0) @(negedge CLK);
            if (e < INIT_CYC && mem_WE === 1'b0) begin
                mask = mask | (1 << mem_ADDRESS);
                nstb++;
            end
            if (e == INIT_CYC - 1) chk("t1_done_at_7", 32'(init_done), 32'd0);
            if (e == INIT_CYC) chk("t1_done_at_8", 32'(init_done), 32'd1);
        end
        chk("t1_strobes", 32'(nstb), 32'd4);
        chk("t1_strobe_mask", 32'(mask), 32'hF);
        for (int i = 0; i < DEPTH; i++) do_read(AW'(i), 8'h00, 0);

        // RD_WAIT=3 instance without clear
        bus6.req_valid = 1'b1; bus6.req_we = 1'b1; bus6.req_addr = 2'd1; bus6.req_wdata = 8'h5A;
        @(negedge CLK);
        bus6.req_valid = 1'b0;
        repeat (3) @(negedge CLK);
        chk("t6_wr_ready", 32'(bus6.req_ready), 32'd1);
        for (int k = 0; k < 2; k++) begin
            bus6.req_valid = 1'b1; bus6.req_we = 1'b0; bus6.req_addr = (k == 0) ? 2'd1 : 2'd2;
            @(negedge CLK);
            bus6.req_valid = 1'b0;
            lat = 0;
            while (!bus6.rsp_valid && lat < 50) begin
                @(negedge CLK);
                lat++;
            end
            chk("t6_latency", 32'(lat), 32'd3);
            chk("t6_data", 32'(bus6.rsp_data), (k == 0) ? 32'h5A : 32'hEE);
            bus6.rsp_ready = 1'b1;
            @(negedge CLK);
            bus6.rsp_ready = 1'b0;
            chk("t6_valid_drop", 32'(bus6.rsp_valid), 32'd0);
        end

        // write then read back
        do_write(2'd2, 8'hA5);
        do_read(2'd2, 8'hA5, 0);

        // back-to-back writes then reads in order
        for (int i = 0; i < DEPTH; i++) do_write(AW'(i), 8'(8'h10 + i));
        for (int i = 0; i < DEPTH; i++) do_read(AW'(i), 8'(8'h10 + i), 0);

        // consumer stall
        do_read(2'd1, 8'h11, 5);

        // reset during the write strobe aborts and reruns the clear
        wait_ready();
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 2'd1; bus.req_wdata = 8'h77;
        @(negedge CLK);
        bus.req_valid = 1'b0;
        @(negedge CLK);
        chk("t5_in_strobe", 32'(mem_WE), 32'd0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("t5_we_after_rst", 32'(mem_WE), 32'd1);
        chk("t5_done_after_rst", 32'(init_done), 32'd0);
        wait_init();
        for (int i = 0; i < DEPTH; i++) begin
            sh[i] = 8'h00;
            do_read(AW'(i), 8'h00, 0);
        end

        // randomized traffic against the shadow memory and the cycle model
        for (int it = 0; it < 250; it++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, DEPTH - 1));
            case ($urandom_range(0, 2))
                0: do_write(a, DW'($urandom));
                1: do_read(a, sh[a], $urandom_range(0, 3));
                default: begin
                    repeat ($urandom_range(1, 3)) begin
                        @(negedge CLK);
                        bus.rsp_ready = 1'($urandom);
                        bus.req_we = 1'($urandom);
                    end
                    bus.rsp_ready = 1'b0;
                end
            endcase
        end

        repeat (2) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
